// File: rtl/iot_multi_monitor.sv
// iot_multi_monitor
//   Multi-channel active-device monitor. Each of N_CH channels holds an up/down counter driven by
//   its own change/on_off strobe pair, with selectable wrap or saturate arithmetic and sticky
//   overflow/underflow flags. A registered aggregate total feeds a threshold alarm FSM with
//   release hysteresis. Sits between the device-event decoder and status/interrupt logic.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   change_i      per-channel update enable
//   on_off_i      per-channel direction (1 = up, 0 = down), ignored when change_i bit is 0
//   thr_load_i    load thr_value_i into the threshold register
//   thr_value_i   new threshold (TW bits)
//   flag_clr_i    clear all sticky ovf/unf flags (a same-cycle set wins)
//   count_out_o   channel i at [i*WIDTH +: WIDTH], registered
//   total_o       registered sum of all channel counters (TW bits, cannot overflow)
//   alarm_o       threshold alarm, registered
//   ovf_o         sticky: up request seen at max count
//   unf_o         sticky: down request seen at zero
module iot_multi_monitor #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned N_CH        = 4,
  parameter bit          SAT_MODE    = 1'b0,
  parameter int unsigned HYST        = 2,
  parameter int unsigned DEFAULT_THR = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CH-1:0]                   change_i,
  input  logic [N_CH-1:0]                   on_off_i,
  input  logic                              thr_load_i,
  input  logic [WIDTH+$clog2(N_CH)-1:0]     thr_value_i,
  input  logic                              flag_clr_i,
  output logic [N_CH*WIDTH-1:0]             count_out_o,
  output logic [WIDTH+$clog2(N_CH)-1:0]     total_o,
  output logic                              alarm_o,
  output logic [N_CH-1:0]                   ovf_o,
  output logic [N_CH-1:0]                   unf_o
);

  localparam int unsigned TW = WIDTH + $clog2(N_CH);

  localparam logic [WIDTH-1:0] CntMax  = '1;
  localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
  localparam logic [TW-1:0]    ThrRst  = TW'(DEFAULT_THR);
  localparam logic [TW-1:0]    HystVal = TW'(HYST);

  typedef enum logic {StIdle, StAlarm} alarm_st_e;

  logic [WIDTH-1:0] cnt_q [N_CH];
  logic [WIDTH-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [N_CH-1:0]  unf_q, unf_d;
  logic [TW-1:0]    total_q, total_d;
  logic [TW-1:0]    thr_q, thr_d;
  alarm_st_e        st_q, st_d;
  logic             release_hit;

  // ---------------------------------------------------------------------------------------------
  // Channel counters and sticky flags
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    // Clear first so that a set in the same cycle overrides it.
    ovf_d = ovf_q & ~{N_CH{flag_clr_i}};
    unf_d = unf_q & ~{N_CH{flag_clr_i}};
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (change_i[i]) begin
        if (on_off_i[i]) begin
          if (cnt_q[i] == CntMax) begin
            ovf_d[i] = 1'b1;
            if (SAT_MODE) begin
              cnt_d[i] = CntMax;
            end else begin
              cnt_d[i] = '0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            unf_d[i] = 1'b1;
            if (SAT_MODE) begin
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = CntMax;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - CntOne;
          end
        end
      end
    end
  end

  // Total is summed from next-state counts so it lines up with count_out_o on the same edge.
  always_comb begin
    total_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      total_d = total_d + TW'(cnt_d[i]);
    end
  end

  always_comb begin
    thr_d = thr_q;
    if (thr_load_i) begin
      thr_d = thr_value_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q   <= '0;
      unf_q   <= '0;
      total_q <= '0;
      thr_q   <= ThrRst;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      total_q <= total_d;
      thr_q   <= thr_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Alarm FSM, evaluated on the registered total against the registered threshold
  // ---------------------------------------------------------------------------------------------
  // Release level is threshold - HYST clamped at zero; with a clamped level nothing is below it,
  // so release is taken when the total reaches zero instead.
  always_comb begin
    if (thr_q <= HystVal) begin
      release_hit = (total_q == '0);
    end else begin
      release_hit = (total_q < (thr_q - HystVal));
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle: begin
        if (total_q >= thr_q) begin
          st_d = StAlarm;
        end
      end
      StAlarm: begin
        if (release_hit) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    count_out_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      count_out_o[i*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

  assign total_o = total_q;
  assign alarm_o = (st_q == StAlarm);
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_iot_multi_monitor.sv
// Testbench for iot_multi_monitor: a wrap-mode and a saturate-mode instance share the same
// stimulus; a behavioural model pushes per-cycle expectations into queues, a monitor pops and
// compares them. Directed checks cover reset, wrap/saturate ends, flag priority, simultaneous
// updates, alarm hysteresis and threshold loads.
module tb_iot_multi_monitor;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int TW   = 10;
  localparam int HYST = 2;
  localparam int DTHR = 16;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  change;
  logic [N-1:0]  on_off;
  logic          thr_load;
  logic [TW-1:0] thr_value;
  logic          flag_clr;

  logic [N*W-1:0] count0, count1;
  logic [TW-1:0]  total0, total1;
  logic           alarm0, alarm1;
  logic [N-1:0]   ovf0, ovf1, unf0, unf1;

  always #5 clk = ~clk;

  iot_multi_monitor #(
    .WIDTH(W), .N_CH(N), .SAT_MODE(1'b0), .HYST(HYST), .DEFAULT_THR(DTHR)
  ) u_dut_wrap (
    .clk(clk), .rst(rst), .change_i(change), .on_off_i(on_off), .thr_load_i(thr_load),
    .thr_value_i(thr_value), .flag_clr_i(flag_clr), .count_out_o(count0), .total_o(total0),
    .alarm_o(alarm0), .ovf_o(ovf0), .unf_o(unf0)
  );

  iot_multi_monitor #(
    .WIDTH(W), .N_CH(N), .SAT_MODE(1'b1), .HYST(HYST), .DEFAULT_THR(DTHR)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .change_i(change), .on_off_i(on_off), .thr_load_i(thr_load),
    .thr_value_i(thr_value), .flag_clr_i(flag_clr), .count_out_o(count1), .total_o(total1),
    .alarm_o(alarm1), .ovf_o(ovf1), .unf_o(unf1)
  );

  typedef struct packed {
    logic [N*W-1:0] cnt;
    logic [TW-1:0]  total;
    logic           alarm;
    logic [N-1:0]   ovf;
    logic [N-1:0]   unf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Behavioural model state, index 0 = wrap instance, 1 = saturate instance.
  int       m_cnt   [2][N];
  logic [N-1:0] m_ovf [2];
  logic [N-1:0] m_unf [2];
  int       m_total [2];
  bit       m_alarm [2];
  int       m_thr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) m_cnt[m][i] = 0;
      m_ovf[m]   = '0;
      m_unf[m]   = '0;
      m_total[m] = 0;
      m_alarm[m] = 1'b0;
    end
    m_thr = DTHR;
  endtask

  // Effect of one clock edge with the given inputs; pushes the expected post-edge outputs.
  task automatic model_step(input logic [N-1:0] c, input logic [N-1:0] o, input logic ld,
                            input logic [TW-1:0] v, input logic clr);
    exp_t e;
    bit   rel;
    for (int m = 0; m < 2; m++) begin
      // Alarm decision uses the total and threshold visible before this edge.
      if (!m_alarm[m]) begin
        m_alarm[m] = (m_total[m] >= m_thr);
      end else begin
        if (m_thr <= HYST) rel = (m_total[m] == 0);
        else               rel = (m_total[m] < m_thr - HYST);
        if (rel) m_alarm[m] = 1'b0;
      end
      if (clr) begin
        m_ovf[m] = '0;
        m_unf[m] = '0;
      end
      m_total[m] = 0;
      for (int i = 0; i < N; i++) begin
        if (c[i]) begin
          if (o[i]) begin
            if (m_cnt[m][i] == CMAX) m_ovf[m][i] = 1'b1;
            if (m == 1) m_cnt[m][i] = (m_cnt[m][i] + 1 > CMAX) ? CMAX : m_cnt[m][i] + 1;
            else        m_cnt[m][i] = (m_cnt[m][i] + 1) % (CMAX + 1);
          end else begin
            if (m_cnt[m][i] == 0) m_unf[m][i] = 1'b1;
            if (m == 1) m_cnt[m][i] = (m_cnt[m][i] == 0) ? 0 : m_cnt[m][i] - 1;
            else        m_cnt[m][i] = (m_cnt[m][i] + CMAX) % (CMAX + 1);
          end
        end
        m_total[m] += m_cnt[m][i];
        e.cnt[i*W +: W] = m_cnt[m][i][W-1:0];
      end
      e.total = m_total[m][TW-1:0];
      e.alarm = m_alarm[m];
      e.ovf   = m_ovf[m];
      e.unf   = m_unf[m];
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (ld) m_thr = int'(v);
  endtask

  task automatic step(input logic [N-1:0] c, input logic [N-1:0] o, input logic ld,
                      input logic [TW-1:0] v, input logic clr);
    @(negedge clk);
    change    = c;
    on_off    = o;
    thr_load  = ld;
    thr_value = v;
    flag_clr  = clr;
    model_step(c, o, ld, v, clr);
  endtask

  task automatic idle();
    step('0, '0, 1'b0, '0, 1'b0);
  endtask

  // Wait for the edge that applies the last step, then sample.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt_w"},   count0, 0);
    check({tag, "_cnt_s"},   count1, 0);
    check({tag, "_total_w"}, total0, 0);
    check({tag, "_total_s"}, total1, 0);
    check({tag, "_alarm_w"}, alarm0, 0);
    check({tag, "_alarm_s"}, alarm1, 0);
    check({tag, "_flags_w"}, {ovf0, unf0}, 0);
    check({tag, "_flags_s"}, {ovf1, unf1}, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero(tag);
    change    = '0;
    on_off    = '0;
    thr_load  = 1'b0;
    thr_value = '0;
    flag_clr  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: one expectation per applied step.
  always @(posedge clk) begin
    #1;
    if (!rst && q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check("sb_cnt_w",   count0, e0.cnt);
      check("sb_total_w", total0, e0.total);
      check("sb_alarm_w", alarm0, e0.alarm);
      check("sb_ovf_w",   ovf0,   e0.ovf);
      check("sb_unf_w",   unf0,   e0.unf);
      check("sb_cnt_s",   count1, e1.cnt);
      check("sb_total_s", total1, e1.total);
      check("sb_alarm_s", alarm1, e1.alarm);
      check("sb_ovf_s",   ovf1,   e1.ovf);
      check("sb_unf_s",   unf1,   e1.unf);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]  c, o;
    logic          ld, clr;
    logic [TW-1:0] v;
    int            bias;
    int            biases [6];

    rst       = 1'b1;
    change    = '0;
    on_off    = '0;
    thr_load  = 1'b0;
    thr_value = '0;
    flag_clr  = 1'b0;
    model_reset();
    #1;
    check_zero("rst_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-count.
    repeat (5) step(4'hF, 4'hF, 1'b0, '0, 1'b0);
    do_reset("rst_mid");

    // Wrap vs saturate on ch0.
    repeat (256) step(4'h1, 4'h1, 1'b0, '0, 1'b0);
    settle();
    check("wrap_cnt0_w", count0[7:0], 0);
    check("wrap_ovf0_w", ovf0[0], 1);
    check("sat_cnt0_s",  count1[7:0], 255);
    step(4'h1, 4'h0, 1'b0, '0, 1'b0);
    settle();
    check("wrap_dn_cnt0_w", count0[7:0], 255);
    check("wrap_dn_unf0_w", unf0[0], 1);
    do_reset("rst_t2");

    // Saturate ch1, then flag_clr together with an up at max.
    repeat (300) step(4'h2, 4'h2, 1'b0, '0, 1'b0);
    settle();
    check("sat_cnt1_s", count1[15:8], 255);
    check("sat_ovf1_s", ovf1[1], 1);
    check("wrap_cnt1_w", count0[15:8], 44);
    step(4'h2, 4'h2, 1'b0, '0, 1'b1);
    settle();
    check("clr_set_ovf1_s", ovf1[1], 1);
    check("clr_ovf1_w",     ovf0[1], 0);
    check("clr_cnt1_s",     count1[15:8], 255);
    do_reset("rst_t3");

    // Simultaneous changes from {3,3,3,3}.
    repeat (3) step(4'hF, 4'hF, 1'b0, '0, 1'b0);
    step(4'hF, 4'h5, 1'b0, '0, 1'b0);
    settle();
    check("simul_cnt_w",   count0, 32'h0204_0204);
    check("simul_total_w", total0, 12);
    do_reset("rst_t4");

    // Alarm hysteresis with default threshold 16.
    repeat (15) step(4'h1, 4'h1, 1'b0, '0, 1'b0);
    step(4'h1, 4'h1, 1'b0, '0, 1'b0);
    settle();
    check("hys_total16", total0, 16);
    check("hys_alarm_lag", alarm0, 0);
    idle();
    settle();
    check("hys_alarm_on", alarm0, 1);
    step(4'h1, 4'h0, 1'b0, '0, 1'b0);
    step(4'h1, 4'h0, 1'b0, '0, 1'b0);
    idle();
    settle();
    check("hys_total14", total0, 14);
    check("hys_alarm_hold14", alarm0, 1);
    step(4'h1, 4'h0, 1'b0, '0, 1'b0);
    idle();
    settle();
    check("hys_alarm_off13", alarm0, 0);
    do_reset("rst_t5");

    // Threshold loads around a total of 10.
    repeat (10) step(4'h1, 4'h1, 1'b0, '0, 1'b0);
    idle();
    step('0, '0, 1'b1, 10'd8, 1'b0);
    settle();
    check("thr8_alarm_lag", alarm0, 0);
    idle();
    settle();
    check("thr8_alarm_on", alarm0, 1);
    step('0, '0, 1'b1, 10'd20, 1'b0);
    idle();
    settle();
    check("thr20_alarm_off", alarm0, 0);

    // Randomised phases with varying up bias; one reset in the middle.
    biases = '{100, 0, 90, 50, 10, 100};
    for (int p = 0; p < 6; p++) begin
      bias = biases[p];
      if (p == 3) do_reset("rst_rand");
      for (int k = 0; k < 500; k++) begin
        c = 4'($urandom_range(15, 0));
        for (int i = 0; i < N; i++) o[i] = ($urandom_range(99, 0) < bias);
        ld  = ($urandom_range(19, 0) == 0);
        if ($urandom_range(1, 0) == 0) v = 10'($urandom_range(1023, 0));
        else                            v = 10'($urandom_range(40, 0));
        clr = ($urandom_range(29, 0) == 0);
        step(c, o, ld, v, clr);
      end
    end

    idle();
    settle();
    check("sb_drain", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
